au_sequencer: RTL and testbench

Multi-cycle micro-sequencer for the model machine: fetches 8-bit instructions from memory, decodes them, and drives the arithmetic unit's enable and 4-bit op code plus register-file, PC, IR, memory and output-port strobes. It sits between the memory interface, PC, IR, register file (4 × 8-bit, two read ports A/B, one write port) and the AU. It latches the AU greater-flag for conditional jumps and guards every memory handshake with a timeout.

---
 rtl/au_sequencer_if.sv | 37 +++
 rtl/au_sequencer.sv | 116 +++++++++++
 tb/tb_au_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/au_sequencer_if.sv
// Bundle of handshake, strobe and status signals between the micro-sequencer and
// the rest of the model machine (memory, PC, IR, register file, AU, output port).
interface au_sequencer_if;
  logic       start;
  logic [7:0] ir;
  logic       mem_ack;
  logic       gf;
  logic       mem_rd;
  logic       mem_wr;
  logic       addr_sel;
  logic       ir_ld;
  logic       pc_inc;
  logic       pc_ld;
  logic       au_en;
  logic [3:0] ac;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       reg_we;
  logic [1:0] wsel;
  logic       out_ld;
  logic       flag;
  logic       busy;
  logic       halted;
  logic       err;

  modport master (
    input  start, ir, mem_ack, gf,
    output mem_rd, mem_wr, addr_sel, ir_ld, pc_inc, pc_ld, au_en, ac,
           sel_a, sel_b, reg_we, wsel, out_ld, flag, busy, halted, err
  );

  modport slave (
    output start, ir, mem_ack, gf,
    input  mem_rd, mem_wr, addr_sel, ir_ld, pc_inc, pc_ld, au_en, ac,
           sel_a, sel_b, reg_we, wsel, out_ld, flag, busy, halted, err
  );
endinterface

// File: rtl/au_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the model machine. Moore outputs
// except ir_ld/pc_inc/pc_ld, which fire in the memory-ack cycle.
module au_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  au_sequencer_if.master bus
);

  localparam logic [3:0] OP_HLT  = 4'b0000;
  localparam logic [3:0] OP_MOVA = 4'b0100;
  localparam logic [3:0] OP_MOVB = 4'b0101;
  localparam logic [3:0] OP_JGF  = 4'b0111;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_OUT  = 4'b1101;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEMW, S_FETCH2, S_HALT
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       flag_q, flag_d;
  logic       err_q, err_d;

  logic [3:0] opcode;
  logic       mem_state;
  logic       timeout;

  assign opcode    = bus.ir[7:4];
  assign mem_state = (state_q == S_FETCH) || (state_q == S_FETCH2) || (state_q == S_MEMW);
  // The ack on the MEM_TIMEOUT-th request cycle still wins over the abort.
  assign timeout   = !bus.mem_ack && (cnt_q == 8'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: if (bus.start) state_d = S_FETCH;
      S_FETCH, S_FETCH2, S_MEMW: begin
        if (bus.mem_ack) begin
          state_d = (state_q == S_FETCH) ? S_DECODE : S_FETCH;
        end else if (timeout) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_MOVA, OP_OUT: state_d = S_EXEC;
          OP_MOVB: state_d = S_MEMW;
          OP_JGF:  state_d = S_FETCH2;
          OP_HLT:  state_d = S_HALT;
          default: begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (opcode == OP_ADD || opcode == OP_SUB) flag_d = bus.gf;
      end
      S_HALT: begin
        if (bus.start) begin
          state_d = S_FETCH;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Counter restarts on every entry into a request state, including FETCH after an ack.
    cnt_d = (mem_state && state_d == state_q) ? cnt_q + 8'd1 : 8'd0;
  end

  always_comb begin
    bus.mem_rd   = (state_q == S_FETCH) || (state_q == S_FETCH2);
    bus.mem_wr   = (state_q == S_MEMW);
    bus.addr_sel = (state_q == S_MEMW);
    bus.ir_ld    = (state_q == S_FETCH) && bus.mem_ack;
    bus.pc_ld    = (state_q == S_FETCH2) && bus.mem_ack && flag_q;
    bus.pc_inc   = ((state_q == S_FETCH) && bus.mem_ack) ||
                   ((state_q == S_FETCH2) && bus.mem_ack && !flag_q);
    bus.au_en    = (state_q == S_EXEC) || (state_q == S_MEMW);
    bus.ac       = bus.au_en ? opcode : 4'b0000;
    bus.reg_we   = (state_q == S_EXEC) &&
                   (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_MOVA);
    bus.out_ld   = (state_q == S_EXEC) && (opcode == OP_OUT);
    bus.busy     = (state_q != S_IDLE) && (state_q != S_HALT);
    bus.halted   = (state_q == S_HALT);
    bus.flag     = flag_q;
    bus.err      = err_q;
  end

  assign bus.sel_a = bus.ir[1:0];
  assign bus.sel_b = bus.ir[3:2];
  assign bus.wsel  = bus.ir[3:2];

endmodule

// File: tb/tb_au_sequencer.sv
// Directed bench for au_sequencer: surrounds it with a small model machine (memory,
// PC, IR, register file, AU) and checks strobes and architectural effects step by step.
module tb_au_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  au_sequencer_if bus();

  au_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Environment model
  logic [7:0] mem [256];
  logic [7:0] rf  [4];
  logic [7:0] pc_q, ir_q, out_q, wr_addr_q, wr_data_q, wcnt;
  logic [7:0] au_a, au_b, au_t, mem_addr, rdata;
  int         ack_dly;
  logic       ld_en;
  logic [7:0] ld_pc, ld_ir;
  logic [7:0] ld_rf [4];

  assign au_a     = rf[bus.sel_a];
  assign au_b     = rf[bus.sel_b];
  assign mem_addr = bus.addr_sel ? au_b : pc_q;
  assign rdata    = mem[mem_addr];

  always_comb begin
    au_t = au_a;
    case (bus.ac)
      4'b1000: au_t = au_a + au_b;
      4'b1001: au_t = au_b - au_a;
      default: au_t = au_a;
    endcase
  end

  assign bus.gf      = bus.au_en && (bus.ac == 4'b1001) && (au_b > au_a);
  assign bus.ir      = ir_q;
  assign bus.mem_ack = (bus.mem_rd || bus.mem_wr) && (int'(wcnt) >= ack_dly);

  always @(posedge clk) begin
    if (ld_en) begin
      pc_q <= ld_pc;
      ir_q <= ld_ir;
      for (int k = 0; k < 4; k++) rf[k] <= ld_rf[k];
    end else begin
      if (bus.ir_ld) ir_q <= rdata;
      if (bus.pc_ld) pc_q <= rdata;
      else if (bus.pc_inc) pc_q <= pc_q + 8'd1;
      if (bus.reg_we) rf[bus.wsel] <= au_t;
    end
    if (bus.out_ld) out_q <= au_t;
    if (bus.mem_wr && bus.mem_ack) begin
      wr_addr_q <= mem_addr;
      wr_data_q <= au_t;
    end
    if ((bus.mem_rd || bus.mem_wr) && !bus.mem_ack) wcnt <= wcnt + 8'd1;
    else wcnt <= 8'd0;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] pc, input logic [7:0] r0, input logic [7:0] r1,
                      input logic [7:0] r2, input logic [7:0] r3, input logic [7:0] ir);
    ld_pc = pc; ld_ir = ir;
    ld_rf[0] = r0; ld_rf[1] = r1; ld_rf[2] = r2; ld_rf[3] = r3;
    ld_en = 1'b1;
    step();
    ld_en = 1'b0;
  endtask

  task automatic kick();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h86;                       // ADD r1,r2
    mem[8'h10] = 8'h96;                       // SUB r1,r2
    mem[8'h11] = 8'h70; mem[8'h12] = 8'h40;   // JGF 0x40
    mem[8'h20] = 8'h56;                       // MOVB [r1],r2
    mem[8'h60] = 8'hF0;                       // illegal
    rst = 1'b1; bus.start = 1'b0; ack_dly = 0; ld_en = 1'b0;
    wcnt = 8'd0; out_q = 8'd0; wr_addr_q = 8'd0; wr_data_q = 8'd0;
    step();
    load(8'h00, 8'h00, 8'h05, 8'h03, 8'h00, 8'h86);
    step();

    // Reset state
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_mem_rd", bus.mem_rd, 1'b0);
    chk("rst_halted", bus.halted, 1'b0);
    chk("rst_ac", bus.ac, 4'h0);
    chk("rst_sel_a", bus.sel_a, 2'd2);
    chk("rst_wsel", bus.wsel, 2'd1);
    rst = 1'b0;
    step();

    // ADD r1,r2 then HLT
    kick();
    chk("add_f_rd", bus.mem_rd, 1'b1);
    chk("add_f_irld", bus.ir_ld, 1'b1);
    chk("add_f_pcinc", bus.pc_inc, 1'b1);
    chk("add_f_busy", bus.busy, 1'b1);
    step();
    chk("add_d_rd", bus.mem_rd, 1'b0);
    chk("add_d_auen", bus.au_en, 1'b0);
    step();
    chk("add_e_auen", bus.au_en, 1'b1);
    chk("add_e_ac", bus.ac, 4'b1000);
    chk("add_e_we", bus.reg_we, 1'b1);
    chk("add_e_wsel", bus.wsel, 2'd1);
    step();
    chk("add_r1", rf[1], 8'h08);
    chk("add_flag", bus.flag, 1'b0);
    chk("add_pc", pc_q, 8'h01);
    step(); step();
    chk("hlt_halted", bus.halted, 1'b1);
    chk("hlt_err", bus.err, 1'b0);
    chk("hlt_busy", bus.busy, 1'b0);

    // SUB 7-2 sets flag, JGF taken to 0x40
    load(8'h10, 8'h00, 8'h07, 8'h02, 8'h00, 8'h00);
    kick(); step(); step();
    chk("sub_e_ac", bus.ac, 4'b1001);
    chk("sub_e_we", bus.reg_we, 1'b1);
    step();
    chk("sub_r1", rf[1], 8'h05);
    chk("sub_flag", bus.flag, 1'b1);
    step(); step();
    chk("jgf_t_rd", bus.mem_rd, 1'b1);
    chk("jgf_t_pcld", bus.pc_ld, 1'b1);
    chk("jgf_t_pcinc", bus.pc_inc, 1'b0);
    step();
    chk("jgf_t_pc", pc_q, 8'h40);
    step(); step();
    chk("jgf_t_halt", bus.halted, 1'b1);

    // Illegal opcode; flag survives HALT
    load(8'h60, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    kick(); step(); step();
    chk("ill_halted", bus.halted, 1'b1);
    chk("ill_err", bus.err, 1'b1);
    chk("ill_flag", bus.flag, 1'b1);

    // Reset mid-FETCH
    load(8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    ack_dly = 1000;
    kick();
    chk("mid_err_clr", bus.err, 1'b0);
    step();
    chk("mid_rd", bus.mem_rd, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0; ack_dly = 0;
    chk("mid_rst_rd", bus.mem_rd, 1'b0);
    chk("mid_rst_flag", bus.flag, 1'b0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_halt", bus.halted, 1'b0);

    // SUB 2-7 clears flag, JGF not taken
    load(8'h10, 8'h00, 8'h02, 8'h07, 8'h00, 8'h00);
    kick(); step(); step(); step();
    chk("sub2_r1", rf[1], 8'hFB);
    chk("sub2_flag", bus.flag, 1'b0);
    step(); step();
    chk("jgf_n_pcld", bus.pc_ld, 1'b0);
    chk("jgf_n_pcinc", bus.pc_inc, 1'b1);
    step();
    chk("jgf_n_pc", pc_q, 8'h13);
    step(); step();

    // MOVB with ack in the 4th write cycle
    load(8'h20, 8'h00, 8'h30, 8'hA5, 8'h00, 8'h00);
    kick(); step();
    ack_dly = 3;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("movb_wr", bus.mem_wr, 1'b1);
      chk("movb_asel", bus.addr_sel, 1'b1);
      chk("movb_auen", bus.au_en, 1'b1);
      chk("movb_ac", bus.ac, 4'b0101);
      chk("movb_ack", bus.mem_ack, (i == 3));
      step();
    end
    ack_dly = 0;
    chk("movb_done_wr", bus.mem_wr, 1'b0);
    chk("movb_fetch", bus.mem_rd, 1'b1);
    chk("movb_addr", wr_addr_q, 8'h30);
    chk("movb_data", wr_data_q, 8'hA5);
    step(); step();

    // PC wrap
    load(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    kick();
    chk("wrap_pcinc", bus.pc_inc, 1'b1);
    step();
    chk("wrap_pc", pc_q, 8'h00);
    step();

    // Fetch timeout after 15 request cycles
    load(8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    ack_dly = 1000;
    kick();
    for (int i = 0; i < 15; i++) begin
      chk("to_rd", bus.mem_rd, 1'b1);
      step();
    end
    chk("to_halted", bus.halted, 1'b1);
    chk("to_err", bus.err, 1'b1);
    chk("to_rd_drop", bus.mem_rd, 1'b0);
    ack_dly = 0;
    kick();
    chk("to_restart_err", bus.err, 1'b0);
    chk("to_restart_rd", bus.mem_rd, 1'b1);
    step(); step();

    // Ack on the 15th request cycle is accepted
    load(8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    ack_dly = 14;
    kick();
    for (int i = 0; i < 14; i++) step();
    chk("late_irld", bus.ir_ld, 1'b1);
    step();
    ack_dly = 0;
    chk("late_busy", bus.busy, 1'b1);
    chk("late_halted", bus.halted, 1'b0);
    step();
    chk("late_hlt_err", bus.err, 1'b0);

    // Reset clears a latched error in HALT
    load(8'h60, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    kick(); step(); step();
    chk("err_before_rst", bus.err, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("err_after_rst", bus.err, 1'b0);
    chk("halt_after_rst", bus.halted, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
